// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset vector, NOP encoding, fetch FSM states, exception codes.
package mips_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;

  typedef enum logic {
    F_REQ  = 1'b0,
    F_HOLD = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit_fd_reg.sv
// Enable/reset pipeline register carrying {pc, instr, exc} between two pipeline stages.
module fd_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] nxt_pc,
  input  logic [DATA_W-1:0] nxt_instr,
  input  logic              nxt_exc,
  output logic [DATA_W-1:0] d_pc,
  output logic [DATA_W-1:0] d_instr,
  output logic              d_exc
);
  always_ff @(posedge clk) begin
    if (reset) begin
      d_pc    <= '0;
      d_instr <= '0;
      d_exc   <= 1'b0;
    end else if (en) begin
      d_pc    <= nxt_pc;
      d_instr <= nxt_instr;
      d_exc   <= nxt_exc;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// MIPS IF stage: PC register, variable-latency imem handshake, skid buffer, F/D register.
// Optional macro FETCH_ADDR_EXC_EN: illegal fetch addresses raise AdEL on d_exc instead of fetching.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
`ifdef FETCH_ADDR_EXC_EN
  output logic        d_exc,
`endif
  output logic        f_busy
);
  fetch_state_e state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  instr_buf;
  logic         buf_exc;
  logic         illegal;
  logic         ack_eff;
  logic         advance;
  logic [31:0]  fd_instr;
  logic         fd_exc;

`ifdef FETCH_ADDR_EXC_EN
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;
  assign illegal = (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= IM_LIMIT);
`else
  localparam logic [32:0] UNUSED_IM_LIMIT = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;
  logic unused_d_exc;
  assign illegal = 1'b0;
`endif

  // An illegal address completes immediately without touching memory.
  assign ack_eff   = imem_ack | illegal;
  assign imem_req  = (state == F_REQ) && !illegal && !reset;
  assign imem_addr = pc;
  assign f_pc      = pc;
  assign f_busy    = (state == F_REQ) && !ack_eff;

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    fd_instr  = illegal ? NOP : imem_rdata;
    fd_exc    = illegal;
    case (state)
      F_REQ: begin
        if (ack_eff) begin
          if (stall) state_nxt = F_HOLD;
          else       advance   = 1'b1;
        end
      end
      F_HOLD: begin
        fd_instr = instr_buf;
        fd_exc   = buf_exc;
        if (!stall) begin
          advance   = 1'b1;
          state_nxt = F_REQ;
        end
      end
      default: state_nxt = F_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= F_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (advance) pc <= npc;
    end
  end

  // Skid buffer: validity is implied by state == F_HOLD, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == F_REQ && ack_eff && stall) begin
      instr_buf <= illegal ? NOP : imem_rdata;
      buf_exc   <= illegal;
    end
  end

  fd_reg #(.DATA_W(32)) u_fd_reg (
    .clk       (clk),
    .reset     (reset),
    .en        (advance),
    .nxt_pc    (pc),
    .nxt_instr (fd_instr),
    .nxt_exc   (fd_exc),
    .d_pc      (d_pc),
    .d_instr   (d_instr),
`ifdef FETCH_ADDR_EXC_EN
    .d_exc     (d_exc)
`else
    .d_exc     (unused_d_exc)
`endif
  );
endmodule
